dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder serving the CPU MEM-stage load/store port. Accepts one word request at a time via a req/ack handshake, services it after a fixed programmable latency from an internal word array, and drives a stall signal so the pipeline freezes until the access completes. It replaces the single-cycle data memory behind the MEM stage and is the first step toward cache/off-chip memory timing.

## Interface
- DEPTH, 1024, number of 32-bit words in the array; power of two, ≥ 4
- LATENCY, 4, BUSY cycles per access; legal range 1..255

- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-low
- req_i  input  1  request valid from MEM stage (MemRead | MemWrite)
- we_i  input  1  1 = store, 0 = load; sampled with req_i
- addr_i  input  32  byte address; word index = addr_i[31:2]
- wdata_i  input  32  store data
- rdata_o  output  32  load data, valid while ack_o = 1
- ack_o  output  1  one-cycle completion pulse
- err_o  output  1  access error flag, valid while ack_o = 1
- stall_o  output  1  pipeline freeze request

## Operation
- FSM states: IDLE, BUSY, RESP. Reset → IDLE.
- IDLE: if req_i = 1, latch we_i, addr_i, wdata_i into request registers, load cnt = LATENCY-1, go BUSY. Else stay.
- BUSY: if cnt = 0 go RESP and perform the access at that edge, else cnt ← cnt-1.
- Access at BUSY→RESP edge:
  - error if latched addr[1:0] ≠ 0 or addr[31:2] ≥ DEPTH: no array write, rdata_o ← 0, err_o ← 1.
  - load: rdata_o ← mem[addr[31:2]], err_o ← 0.
  - store: mem[addr[31:2]] ← wdata; rdata_o unchanged; err_o ← 0.
- RESP: ack_o = 1 (registered), then unconditionally IDLE. A req_i present during RESP is not accepted; it is accepted in the next IDLE cycle.
- stall_o (combinational) = (state = IDLE & req_i) | (state = BUSY). Low in RESP, so the pipeline advances on the ack cycle.
- Request is committed once latched: deassertion or change of req_i/addr_i/we_i/wdata_i during BUSY is ignored; the latched access completes.
- Requester must hold req_i and fields stable while stall_o = 1; after ack it presents the next request or drops req_i.
- cnt width 8 bits; no wrap possible since cnt only decrements from LATENCY-1 to 0.
- Memory array is not reset; contents undefined until written.

## Timing
- Reset values: ack_o = 0, err_o = 0, rdata_o = 32'h0, stall_o = 0 (when req_i = 0), state IDLE, cnt = 0.
- Reset asserted mid-access: immediate return to IDLE, ack_o/err_o cleared, pending store discarded (array unchanged).
- Request first seen in cycle 0 (IDLE): BUSY cycles 1..LATENCY, ack_o in cycle LATENCY+1. Total stall_o high for LATENCY+1 cycles (0..LATENCY).
- Back-to-back requests: minimum spacing LATENCY+2 cycles between ack pulses (RESP then IDLE accept).
- rdata_o/err_o hold their values after ack until the next access completes.
- Throughput: one outstanding access; no pipelining.

## Test plan
- Reset: rst_i low for 2 cycles with req_i = 1 → ack_o = 0, err_o = 0, rdata_o = 0, stall_o = 0 during reset; after release stall_o = 1 immediately.
- Store then load, LATENCY = 4: store 32'hDEADBEEF to addr 0x10 in cycle 0 → ack_o in cycle 5, stall_o high cycles 0–4; load 0x10 in cycle 6 → ack_o cycle 11, rdata_o = 32'hDEADBEEF.
- Misaligned/out-of-range: load 0x13 → ack with err_o = 1, rdata_o = 0; store to addr 4*DEPTH → err_o = 1, subsequent load of addr 0 returns prior contents.
- Request changes mid-BUSY: store 0x20 = 32'h1 latched, then addr_i switched to 0x24 and req_i dropped in cycle 2 → ack still in cycle 5; load 0x20 returns 32'h1, 0x24 untouched.
- Reset mid-access: store 0x30 = 32'h55 after earlier 0x30 = 32'hAA; assert rst_i in cycle 3 → no ack; after release load 0x30 returns 32'hAA.
- LATENCY = 1 corner: request in cycle 0 → BUSY cycle 1, ack cycle 2; continuous req_i yields acks in cycles 2, 5, 8.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// One outstanding word access, completed after a fixed programmable latency.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        req_we_r;
  logic [31:0] req_addr_r;
  logic [31:0] req_wdata_r;
  logic [31:0] mem_r [DEPTH];

  logic [29:0]   word_idx_s;
  logic [AW-1:0] mem_idx_s;
  logic          acc_err_s;
  logic          access_s;

  assign word_idx_s = req_addr_r[31:2];
  assign mem_idx_s  = word_idx_s[AW-1:0];
  assign acc_err_s  = (req_addr_r[1:0] != 2'b00) || (word_idx_s >= 30'(DEPTH));
  assign access_s   = (state_r == BUSY) && (cnt_r == 8'd0);

  // Gated by reset so the pipeline is never frozen while the block is held in reset.
  assign stall_o = rst_i & (((state_r == IDLE) & req_i) | (state_r == BUSY));

  // Request FSM: latch, count down the latency, complete the access, pulse ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      req_we_r    <= 1'b0;
      req_addr_r  <= 32'h0;
      req_wdata_r <= 32'h0;
      rdata_o     <= 32'h0;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_o <= 1'b0;
          if (req_i) begin
            req_we_r    <= we_i;
            req_addr_r  <= addr_i;
            req_wdata_r <= wdata_i;
            cnt_r       <= 8'(LATENCY - 1);
            state_r     <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r == 8'd0) begin
            state_r <= RESP;
            ack_o   <= 1'b1;
            if (acc_err_s) begin
              rdata_o <= 32'h0;
              err_o   <= 1'b1;
            end else if (!req_we_r) begin
              rdata_o <= mem_r[mem_idx_s];
              err_o   <= 1'b0;
            end else begin
              err_o   <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        RESP: begin
          ack_o   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ack_o   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Word array store port; a store interrupted by reset at its completion edge is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i && access_s && req_we_r && !acc_err_s) begin
      mem_r[mem_idx_s] <= req_wdata_r;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: randomized and directed accesses
// checked against an associative-array memory model with latency rules.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o, err_o, stall_o;

  logic        req_b, we_b;
  logic [31:0] addr_b, wdata_b;
  logic [31:0] rdata_b;
  logic        ack_b, err_b, stall_b;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [logic [29:0]];
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] pool [8];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .err_o(err_o), .stall_o(stall_o)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .rdata_o(rdata_b), .ack_o(ack_b), .err_o(err_b), .stall_o(stall_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word-addressed memory, error rule, completion at issue + LAT + 1.
  task automatic push_exp(input logic we, input logic [31:0] a, input logic [31:0] wd, input int k);
    exp_t e;
    logic [29:0] w;
    w = a[31:2];
    e.cyc = k + LAT + 1;
    if (a[1:0] != 2'b00 || {2'b00, w} >= 32'(DEPTH)) begin
      e.err = 1'b1;
      e.rdata = 32'h0;
    end else if (we) begin
      mem_m[w] = wd;
      e.err = 1'b0;
      e.rdata = last_rdata;
    end else begin
      e.err = 1'b0;
      e.rdata = mem_m.exists(w) ? mem_m[w] : 32'h0;
    end
    last_rdata = e.rdata;
    exp_q.push_back(e);
  endtask

  // Issue one access from an IDLE cycle; optionally corrupt the request mid-BUSY.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd, input bit swap);
    int k;
    bit seen;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
    k = cyc;
    push_exp(we, a, wd, k);
    seen = 1'b0;
    for (int t = 0; t <= LAT + 1; t++) begin
      @(negedge clk);
      chk("stall", {31'h0, stall_o}, {31'h0, (t <= LAT)});
      if (ack_o) seen = 1'b1;
      @(posedge clk); #1;
      if (swap && t == 1) begin
        addr_i = a + 32'd4;
        wdata_i = ~wd;
        req_i = 1'b0;
      end
    end
    req_i = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ack_timeout: no ack for addr %h issued in cycle %0d", a, k);
    end
  endtask

  task automatic idle_gap(input int n);
    req_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h13; wdata_i = 32'h0;
    req_b = 1'b0; we_b = 1'b0; addr_b = 32'h0; wdata_b = 32'h0;
    pool[0] = 32'h0;  pool[1] = 32'h4;  pool[2] = 32'h10; pool[3] = 32'h20;
    pool[4] = 32'h24; pool[5] = 32'h30; pool[6] = 32'h44; pool[7] = 32'(4 * (DEPTH - 1));

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && ack_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", {31'h0, ack_o}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            chk("err", {31'h0, err_o}, {31'h0, e.err});
            chk("rdata", rdata_o, e.rdata);
          end
        end
      end
    join_none

    // Reset held with a pending request: everything quiet.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ack", {31'h0, ack_o}, 32'h0);
      chk("rst_err", {31'h0, err_o}, 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_stall", {31'h0, stall_o}, 32'h0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    #1;
    chk("stall_after_release", {31'h0, stall_o}, 32'h1);
    access(1'b0, 32'h13, 32'h0, 1'b0);

    for (int i = 0; i < 8; i++) access(1'b1, pool[i], $urandom, 1'b0);

    access(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b0, 32'h10, 32'h0, 1'b0);
    access(1'b0, 32'h13, 32'h0, 1'b0);
    access(1'b1, 32'(4 * DEPTH), 32'hBAD0BAD0, 1'b0);
    access(1'b0, 32'h0, 32'h0, 1'b0);

    access(1'b1, 32'h20, 32'h1, 1'b1);
    access(1'b0, 32'h20, 32'h0, 1'b0);
    access(1'b0, 32'h24, 32'h0, 1'b0);

    // Reset three cycles into a store: the store must vanish.
    access(1'b1, 32'h30, 32'hAA, 1'b0);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h30; wdata_i = 32'h55;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("midrst_stall", {31'h0, stall_o}, 32'h1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_ack", {31'h0, ack_o}, 32'h0);
      chk("midrst_err", {31'h0, err_o}, 32'h0);
      chk("midrst_rdata", rdata_o, 32'h0);
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    rst_n = 1'b1;
    last_rdata = 32'h0;
    access(1'b0, 32'h30, 32'h0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 8) a = pool[sel];
      else if (sel == 8) a = pool[$urandom_range(0, 7)] + 32'($urandom_range(1, 3));
      else a = ($urandom_range(0, 1) == 0) ? 32'(4 * DEPTH) : 32'hFFFF_FFFC;
      access(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 3) == 0));
      idle_gap($urandom_range(0, 2));
    end

    // LATENCY = 1 instance with req held continuously: acks every third cycle.
    req_b = 1'b1; we_b = 1'b0; addr_b = 32'h13;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      chk("l1_ack", {31'h0, ack_b}, {31'h0, (t % 3 == 2)});
      chk("l1_stall", {31'h0, stall_b}, {31'h0, (t % 3 != 2)});
      if (t % 3 == 2) begin
        chk("l1_err", {31'h0, err_b}, 32'h1);
        chk("l1_rdata", rdata_b, 32'h0);
      end
      @(posedge clk); #1;
    end
    req_b = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
